// File: rtl/main_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : main_bus_arbiter
// Description : Two-requester round-robin arbiter for a shared multiplexed
//               address/data bus. Each grant runs one burst:
//               ADDR (1 cycle) -> DATA (DATAPAYLOADSIZE cycles) -> TURN
//               (1 cycle), then back to IDLE for at least one cycle.
// Ports       : clk, resetH          - clock, async active-high reset
//               req, req_rw          - per-requester request / direction
//               req_addr0/1, wdata0/1- per-requester address and write data
//               gnt, done            - one-hot grant, end-of-burst pulse
//               wr_ready             - write beat consumed this cycle
//               rdata, rd_valid      - registered read beat to requester
//               AddrValid, rw        - bus address strobe / direction
//               AddrData_out/_oe/_in - bus drive value, enable, sampled value
// Revision    : 1.0 - initial release
// ============================================================================
module main_bus_arbiter #(
    parameter int DATAWIDTH       = 16,
    parameter int DATAPAYLOADSIZE = 4
) (
    input  logic                 clk,
    input  logic                 resetH,
    input  logic [1:0]           req,
    input  logic [1:0]           req_rw,
    input  logic [DATAWIDTH-1:0] req_addr0,
    input  logic [DATAWIDTH-1:0] req_addr1,
    input  logic [DATAWIDTH-1:0] wdata0,
    input  logic [DATAWIDTH-1:0] wdata1,
    output logic [1:0]           gnt,
    output logic                 wr_ready,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rd_valid,
    output logic [1:0]           done,
    output logic                 AddrValid,
    output logic                 rw,
    output logic [DATAWIDTH-1:0] AddrData_out,
    output logic                 AddrData_oe,
    input  logic [DATAWIDTH-1:0] AddrData_in
);

    localparam logic [3:0] BEATS = 4'(DATAPAYLOADSIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t               state;
    logic                 last_gnt;    // index of the requester granted last
    logic [3:0]           beat_cnt;
    logic [DATAWIDTH-1:0] addr_drive;  // address held for the ADDR cycle, else 0
    logic                 winner;
    logic [DATAWIDTH-1:0] wdata_sel;

    // Contention goes to the requester that was not served last; a lone
    // requester always wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else begin
            winner = req[1];
        end
    end

    assign wdata_sel = gnt[1] ? wdata1 : wdata0;

    // Write beats pass straight through so the requester's current word is on
    // the bus in the same cycle wr_ready tells it the word was taken.
    assign AddrData_out = ((state == DATA) && !rw) ? wdata_sel : addr_drive;

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            beat_cnt    <= 4'd0;
            addr_drive  <= '0;
            gnt         <= 2'b00;
            wr_ready    <= 1'b0;
            rdata       <= '0;
            rd_valid    <= 1'b0;
            done        <= 2'b00;
            AddrValid   <= 1'b0;
            rw          <= 1'b0;
            AddrData_oe <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            done      <= 2'b00;
            rd_valid  <= 1'b0;
            AddrValid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state       <= ADDR;
                        gnt         <= winner ? 2'b10 : 2'b01;
                        last_gnt    <= winner;
                        rw          <= req_rw[winner];
                        addr_drive  <= winner ? req_addr1 : req_addr0;
                        AddrValid   <= 1'b1;
                        AddrData_oe <= 1'b1;
                    end
                end

                ADDR: begin
                    state       <= DATA;
                    beat_cnt    <= BEATS;
                    addr_drive  <= '0;
                    AddrData_oe <= ~rw;   // release the bus for reads
                    wr_ready    <= ~rw;
                end

                DATA: begin
                    if (rw) begin
                        rdata    <= AddrData_in;
                        rd_valid <= 1'b1;
                    end
                    if (beat_cnt != 4'd0) begin
                        beat_cnt <= beat_cnt - 4'd1;
                    end
                    if (beat_cnt <= 4'd1) begin
                        state       <= TURN;
                        done        <= gnt;
                        AddrData_oe <= 1'b0;
                        wr_ready    <= 1'b0;
                    end
                end

                TURN: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    rw    <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_bus_arbiter
// Description : Scoreboard bench for main_bus_arbiter. Stimulus pushes the
//               expected bus/requester events; a monitor pops and compares
//               each one as the DUT presents it. A second instance built
//               with DATAPAYLOADSIZE=1 is checked cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_bus_arbiter;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        resetH;
    logic [1:0]  req, req_rw;
    logic [15:0] req_addr0, req_addr1, wdata0, wdata1, AddrData_in;
    logic [1:0]  gnt, done;
    logic        wr_ready, rd_valid, AddrValid, rw, AddrData_oe;
    logic [15:0] rdata, AddrData_out;

    // Single-beat instance
    logic [1:0]  q_req, q_req_rw, q_gnt, q_done;
    logic [15:0] q_addr0, q_addr1, q_wdata0, q_wdata1, q_in, q_rdata, q_out;
    logic        q_wr_ready, q_rd_valid, q_av, q_rw, q_oe;

    logic [15:0] wbase0, wbase1;
    int          wbeat = 0;
    int          ridx  = 0;

    assign wdata0      = wbase0 + 16'(wbeat);
    assign wdata1      = wbase1 + 16'(wbeat);
    assign AddrData_in = 16'h00A1 + 16'(ridx);

    always #5 clk = ~clk;

    main_bus_arbiter #(.DATAWIDTH(16), .DATAPAYLOADSIZE(NB)) dut (
        .clk(clk), .resetH(resetH), .req(req), .req_rw(req_rw),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .wr_ready(wr_ready), .rdata(rdata), .rd_valid(rd_valid),
        .done(done), .AddrValid(AddrValid), .rw(rw),
        .AddrData_out(AddrData_out), .AddrData_oe(AddrData_oe),
        .AddrData_in(AddrData_in)
    );

    main_bus_arbiter #(.DATAWIDTH(16), .DATAPAYLOADSIZE(1)) dut1 (
        .clk(clk), .resetH(resetH), .req(q_req), .req_rw(q_req_rw),
        .req_addr0(q_addr0), .req_addr1(q_addr1),
        .wdata0(q_wdata0), .wdata1(q_wdata1),
        .gnt(q_gnt), .wr_ready(q_wr_ready), .rdata(q_rdata), .rd_valid(q_rd_valid),
        .done(q_done), .AddrValid(q_av), .rw(q_rw),
        .AddrData_out(q_out), .AddrData_oe(q_oe),
        .AddrData_in(q_in)
    );

    typedef struct {
        int          kind;   // 0 addr, 1 write beat, 2 read beat, 3 done
        logic [15:0] val;
        logic [1:0]  g;
        logic        r;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   av_cyc = 0;
    int   last_done = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d required none at %0t", kind, $time);
        end else begin
            e = sb.pop_front();
            chk("event_kind", e.kind, kind);
            ok = (e.kind == kind);
        end
    endtask

    // Expected sequence for one complete burst.
    task automatic push_burst(input bit who, input bit dir, input logic [15:0] addr,
                              input int beats);
        exp_t        e;
        logic [1:0]  g;
        logic [15:0] wb;
        g  = who ? 2'b10 : 2'b01;
        wb = who ? wbase1 : wbase0;
        e.kind = 0; e.val = addr; e.g = g; e.r = dir;
        sb.push_back(e);
        for (int k = 0; k < beats; k++) begin
            e.kind = dir ? 2 : 1;
            e.val  = dir ? (16'h00A1 + 16'(k)) : (wb + 16'(k));
            sb.push_back(e);
        end
        e.kind = 3; e.val = '0;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (AddrValid) begin
                take(0, e, ok);
                if (ok) begin
                    chk("addr_out", AddrData_out, e.val);
                    chk("addr_gnt", gnt, e.g);
                    chk("addr_rw", rw, e.r);
                    chk("addr_oe", AddrData_oe, 1);
                end
                chk("turnaround_gap", 32'((cyc - last_done) >= 2), 1);
                av_cyc = cyc;
            end
            if (wr_ready) begin
                take(1, e, ok);
                if (ok) begin
                    chk("wr_data", AddrData_out, e.val);
                    chk("wr_gnt", gnt, e.g);
                    chk("wr_oe", AddrData_oe, 1);
                end
            end
            if (rd_valid) begin
                take(2, e, ok);
                if (ok) chk("rd_data", rdata, e.val);
            end
            if (done != 2'b00) begin
                take(3, e, ok);
                if (ok) chk("done_who", done, e.g);
                chk("burst_latency", cyc - av_cyc, NB + 1);
                last_done = cyc;
            end
            if (gnt != 2'b00) begin
                chk("gnt_onehot", 32'($onehot(gnt)), 1);
                if (rw && !AddrValid) chk("read_oe_low", AddrData_oe, 0);
            end
        end
    end

    // Requester / bus data model: advance write word after each consumed
    // beat, advance read word after each sampled beat.
    initial begin
        bit wr_seen;
        forever begin
            @(negedge clk);
            wr_seen = wr_ready;
            @(posedge clk);
            #1;
            if (AddrValid) begin
                wbeat = 0;
                ridx  = 0;
            end else begin
                if (wr_seen)  wbeat++;
                if (rd_valid) ridx++;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || gnt != 2'b00) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual pending=%0d required 0", name, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_av();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!AddrValid && n < 30);
        if (!AddrValid) begin
            checks++;
            errors++;
            $display("FAIL addr_timeout: actual AddrValid=0 required 1");
        end
    endtask

    initial begin
        resetH = 1'b1; req = 2'b00; req_rw = 2'b00;
        req_addr0 = '0; req_addr1 = '0; wbase0 = 16'h5A00; wbase1 = 16'h7700;
        q_req = 2'b00; q_req_rw = 2'b00; q_addr0 = 16'h0C40; q_addr1 = '0;
        q_wdata0 = 16'hBEEF; q_wdata1 = '0; q_in = '0;
        #2;
        chk("rst_gnt", gnt, 0);           chk("rst_done", done, 0);
        chk("rst_wr_ready", wr_ready, 0); chk("rst_rd_valid", rd_valid, 0);
        chk("rst_addrvalid", AddrValid, 0); chk("rst_rw", rw, 0);
        chk("rst_oe", AddrData_oe, 0);    chk("rst_out", AddrData_out, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk); @(negedge clk);
        resetH = 1'b0;

        // Single write from requester 0
        @(negedge clk);
        push_burst(0, 0, 16'h1020, NB);
        req = 2'b01; req_rw = 2'b00; req_addr0 = 16'h1020;
        @(negedge clk);
        req = 2'b00;
        wait_idle("single_write");

        // Single read from requester 1
        push_burst(1, 1, 16'h2004, NB);
        req = 2'b10; req_rw = 2'b10; req_addr1 = 16'h2004;
        @(negedge clk);
        req = 2'b00;
        wait_idle("single_read");

        // Continuous contention: requester 1 was served last, so 0 goes first
        wbase0 = 16'h6000; req_addr0 = 16'h3000; req_addr1 = 16'h4000;
        push_burst(0, 0, 16'h3000, NB);
        push_burst(1, 1, 16'h4000, NB);
        push_burst(0, 0, 16'h3000, NB);
        push_burst(1, 1, 16'h4000, NB);
        req = 2'b11; req_rw = 2'b10;
        for (int b = 0; b < 4; b++) wait_av();
        req = 2'b00;
        wait_idle("contention");

        // Request dropped in the second DATA cycle; burst must still finish
        wbase0 = 16'h1100; req_rw = 2'b00; req_addr0 = 16'h1ABC;
        push_burst(0, 0, 16'h1ABC, NB);
        req = 2'b01;
        @(negedge clk);   // ADDR
        @(negedge clk);   // DATA1
        @(negedge clk);   // DATA2
        req = 2'b00;
        wait_idle("req_drop");

        // Reset in the third DATA cycle: only ADDR and three beats appear
        begin
            exp_t e;
            wbase0 = 16'h2200; req_addr0 = 16'h1440;
            e.kind = 0; e.val = 16'h1440; e.g = 2'b01; e.r = 1'b0;
            sb.push_back(e);
            for (int k = 0; k < 3; k++) begin
                e.kind = 1; e.val = 16'h2200 + 16'(k);
                sb.push_back(e);
            end
        end
        req = 2'b01;
        @(negedge clk);   // ADDR
        req = 2'b00;
        @(negedge clk);   // DATA1
        @(negedge clk);   // DATA2
        @(negedge clk);   // DATA3
        #1 resetH = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, 0);          chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_oe", AddrData_oe, 0);   chk("mid_rst_out", AddrData_out, 0);
        chk("mid_rst_done", done, 0);        chk("mid_rst_rdata", rdata, 0);
        @(negedge clk); @(negedge clk);
        chk("mid_rst_pending", sb.size(), 0);
        wbase0 = 16'h3300; req_addr0 = 16'h1880;
        push_burst(0, 0, 16'h1880, NB);
        resetH = 1'b0;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        wait_idle("post_reset");

        // Single-beat build
        q_req = 2'b01;
        @(negedge clk);
        q_req = 2'b00;
        chk("n1_addr_gnt", q_gnt, 2'b01);  chk("n1_addr_av", q_av, 1);
        chk("n1_addr_out", q_out, 16'h0C40);
        @(negedge clk);
        chk("n1_wr_ready", q_wr_ready, 1); chk("n1_wr_out", q_out, 16'hBEEF);
        chk("n1_no_early_done", q_done, 0);
        @(negedge clk);
        chk("n1_done", q_done, 2'b01);     chk("n1_wr_ready_off", q_wr_ready, 0);
        @(negedge clk);
        chk("n1_idle_gnt", q_gnt, 0);      chk("n1_idle_done", q_done, 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_bus_arbiter.md
MAIN_BUS_ARBITER -- requirements
Module: main_bus_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16, width of address/data bus.
REQ-002 SHALL have parameter DATAPAYLOADSIZE, default 4, data beats per burst (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetH  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  2  per-requester bus request (bit 0 = requester 0, bit 1 = requester 1).
REQ-006 SHALL have port req_rw  input  2  per-requester direction, 1 = read, 0 = write.
REQ-007 SHALL have port req_addr0 / req_addr1  input  DATAWIDTH each  burst start address, page in [15:12].
REQ-008 SHALL have port wdata0 / wdata1  input  DATAWIDTH each  write beat data.
REQ-009 SHALL have port gnt  output  2  one-hot grant, 00 when idle.
REQ-010 SHALL have port wr_ready  output  1  current write beat consumed this cycle.
REQ-011 SHALL have port rdata  output  DATAWIDTH  read beat data to granted requester.
REQ-012 SHALL have port rd_valid  output  1  rdata valid this cycle.
REQ-013 SHALL have port done  output  2  one-cycle pulse to the granted requester at burst end.
REQ-014 SHALL have port AddrValid  output  1  bus address strobe.
REQ-015 SHALL have port rw  output  1  bus direction, 1 = read.
REQ-016 SHALL have port AddrData_out  output  DATAWIDTH  bus drive value.
REQ-017 SHALL have port AddrData_oe  output  1  bus drive enable; top level builds the tri-state.
REQ-018 SHALL have port AddrData_in  input  DATAWIDTH  bus sampled value.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA, TURN.
REQ-020 IDLE: req != 00 -> ADDR next cycle; winner latched into gnt, its req_rw and req_addr latched.
REQ-021 Arbitration SHALL be round-robin: single requester wins; both requesting -> the one not granted last; last-grant pointer resets to 1, so requester 0 wins the first contention.
REQ-022 ADDR (1 cycle): AddrValid=1, AddrData_oe=1, AddrData_out=latched address, rw=latched direction; beat counter loaded with DATAPAYLOADSIZE; -> DATA.
REQ-023 DATA write: AddrData_oe=1, AddrData_out=wdata of granted requester, wr_ready=1 every beat cycle.
REQ-024 DATA read: AddrData_oe=0, rdata=AddrData_in registered, rd_valid=1 the cycle after each beat (exactly DATAPAYLOADSIZE pulses).
REQ-025 Beat counter SHALL decrement once per DATA cycle; counter==1 -> TURN; no wrap below 0.
REQ-026 TURN (1 cycle): AddrData_oe=0, AddrValid=0, done[granted]=1, then gnt=00 and -> IDLE; final read rd_valid coincides with TURN.
REQ-027 Back-to-back bursts SHALL be separated by at least one IDLE cycle (bus turnaround).
REQ-028 Burst latency: write 2+DATAPAYLOADSIZE cycles grant-to-done; read identical.
REQ-029 Requests and req_rw/req_addr changes during ADDR/DATA/TURN SHALL be ignored; a dropped req mid-burst SHALL NOT abort the burst.
REQ-030 gnt SHALL be stable and one-hot from ADDR through TURN.
REQ-031 AddrValid SHALL be high only in ADDR; AddrData_oe and a read burst SHALL never overlap.

Reset
REQ-032 resetH=1 SHALL asynchronously force IDLE, gnt=00, done=00, wr_ready=0, rd_valid=0, AddrValid=0, rw=0, AddrData_oe=0, AddrData_out=0, rdata=0, counter=0, last-grant pointer=1.
REQ-033 Reset mid-burst SHALL abandon the burst with no done pulse; first post-reset cycle is IDLE.

Verification
REQ-034 Single write: req=01, req_rw=00, req_addr0=16'h1020 -> gnt=01; AddrValid=1 one cycle with AddrData_out=16'h1020, rw=0; 4 cycles wr_ready=1; done=01 in TURN; total 6 cycles.
REQ-035 Single read: req=10, req_rw=10, req_addr1=16'h2004, bus returns A1,A2,A3,A4 -> rd_valid 4 pulses, rdata A1..A4 in order, AddrData_oe=0 throughout DATA, done=10.
REQ-036 Contention: req=11 held continuously -> grants alternate 01,10,01,10, each burst separated by one IDLE cycle.
REQ-037 Mid-burst request drop: req0 deasserted in 2nd DATA cycle -> burst completes all 4 beats, done=01 still pulses.
REQ-038 Reset mid-burst: resetH asserted in 3rd DATA cycle -> all outputs at reset values same cycle, no done; after release req=01 starts a fresh ADDR.
REQ-039 DATAPAYLOADSIZE=1 build: single write -> one wr_ready cycle, done in 3rd cycle after grant.
